// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
// Exports the FSM state encoding and the default operand width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sa_state_t;

  localparam int SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fa_cell.sv
// One-bit combinational full adder.
// Ports: a, b, cin in; s (sum bit), cout (majority carry) out.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per cycle through fa_cell, LSB first.
// Ports: clk, rst (sync, high), start, a, b, cin in;
//        busy, done, sum, cout out (all from registered state).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sa_state_t        state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             c_s;
  logic             c_cout;

  fa_cell u_fa (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (carry),
    .s    (c_s),
    .cout (c_cout)
  );

  // New sum bit enters at the MSB; after WIDTH shifts
  // the first (LSB) bit has reached position 0.
  always_comb begin
    acc_next = acc >> 1;
    acc_next[WIDTH-1] = c_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          carry <= c_cout;
          acc   <= acc_next;
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= acc_next;
            cout  <= c_cout;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks for serial_adder.
// Drives a WIDTH=8 and a WIDTH=1 instance from one clock.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start1;
  logic [7:0] a8, b8, sum8;
  logic       cin8, busy8, done8, cout8;
  logic [0:0] a1, b1, sum1;
  logic       cin1, busy1, done1, cout1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8),
    .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8),
    .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start(start1),
    .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1),
    .sum(sum1), .cout(cout1)
  );

  // Issues one addition on u8 and measures what it produced.
  task automatic do_add8(
    input  logic [7:0] ai, bi,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co,
    output int         lat,
    output bit         stable,
    output bit         ovl
  );
    logic [7:0] prev;
    lat = 0; stable = 1'b1; ovl = 1'b0;
    @(posedge clk); #1;
    a8 = ai; b8 = bi; cin8 = ci; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = ~ai; b8 = ~bi; cin8 = ~ci;
    prev = sum8;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (busy8 && done8) ovl = 1'b1;
      if (busy8 && sum8 !== prev) stable = 1'b0;
      if (done8) begin
        lat = k;
        break;
      end
    end
    s = sum8; co = cout8;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start8 = 0; start1 = 0;
    a8 = 0; b8 = 0; cin8 = 0;
    a1 = 0; b1 = 0; cin1 = 0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({busy8, done8, sum8, cout8} !== 11'h0) begin
      fails++;
      $display("FAIL reset8 got b=%b d=%b s=%h c=%b want 0",
               busy8, done8, sum8, cout8);
    end
    tests++;
    if ({busy1, done1, sum1, cout1} !== 4'h0) begin
      fails++;
      $display("FAIL reset1 got b=%b d=%b s=%b c=%b want 0",
               busy1, done1, sum1, cout1);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [7:0] va [4] = '{8'h00, 8'hFF, 8'hA5, 8'h7F};
    logic [7:0] vb [4] = '{8'h00, 8'h01, 8'h5A, 8'h01};
    logic       vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] es [4] = '{8'h00, 8'h00, 8'h00, 8'h80};
    logic       ec [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] s;
    logic co;
    int lat;
    bit st, ov;
    for (int i = 0; i < 4; i++) begin
      do_add8(va[i], vb[i], vc[i], s, co, lat, st, ov);
      tests++;
      if (lat !== 8) begin
        fails++;
        $display("FAIL basic%0d latency got %0d want 8", i, lat);
      end
      tests++;
      if (s !== es[i]) begin
        fails++;
        $display("FAIL basic%0d sum got %h want %h", i, s, es[i]);
      end
      tests++;
      if (co !== ec[i]) begin
        fails++;
        $display("FAIL basic%0d cout got %b want %b", i, co, ec[i]);
      end
      tests++;
      if (st !== 1'b1) begin
        fails++;
        $display("FAIL basic%0d sum_hold got 0 want 1", i);
      end
    end
  endtask

  task automatic test_width1;
    logic [1:0] exp [8] = '{2'b00, 2'b01, 2'b01, 2'b10,
                            2'b01, 2'b10, 2'b10, 2'b11};
    logic [2:0] v;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      @(posedge clk); #1;
      a1 = v[0]; b1 = v[1]; cin1 = v[2]; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      tests++;
      if (busy1 !== 1'b1) begin
        fails++;
        $display("FAIL w1_%0d busy got %b want 1", i, busy1);
      end
      @(posedge clk); #1;
      tests++;
      if (done1 !== 1'b1) begin
        fails++;
        $display("FAIL w1_%0d done got %b want 1", i, done1);
      end
      tests++;
      if ({cout1, sum1} !== exp[i]) begin
        fails++;
        $display("FAIL w1_%0d result got %b%b want %b",
                 i, cout1, sum1, exp[i]);
      end
    end
  endtask

  task automatic test_ignore_start;
    int dn = 0;
    logic [7:0] s = 8'hxx;
    logic co = 1'bx;
    @(posedge clk); #1;
    a8 = 8'h10; b8 = 8'h20; cin8 = 0; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    repeat (2) @(posedge clk);
    #1;
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (done8) begin
        dn++;
        s = sum8; co = cout8;
      end
    end
    tests++;
    if (dn !== 1) begin
      fails++;
      $display("FAIL ignore done_count got %0d want 1", dn);
    end
    tests++;
    if ({co, s} !== 9'h030) begin
      fails++;
      $display("FAIL ignore result got %b_%h want 0_30", co, s);
    end
  endtask

  task automatic test_abort;
    int dn = 0;
    logic [7:0] s;
    logic co;
    int lat;
    bit st, ov;
    @(posedge clk); #1;
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    tests++;
    if ({busy8, sum8, cout8} !== 10'h0) begin
      fails++;
      $display("FAIL abort state got b=%b s=%h c=%b want 0",
               busy8, sum8, cout8);
    end
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      if (done8) dn++;
    end
    tests++;
    if (dn !== 0) begin
      fails++;
      $display("FAIL abort done_count got %0d want 0", dn);
    end
    do_add8(8'h03, 8'h04, 1'b0, s, co, lat, st, ov);
    tests++;
    if ({co, s, lat} !== {1'b0, 8'h07, 32'd8}) begin
      fails++;
      $display("FAIL abort_fresh got c=%b s=%h lat=%0d want 0 07 8",
               co, s, lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] ra, rb, s;
    logic rc, co;
    logic [8:0] ref_sum;
    int lat;
    bit st, ov;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      ref_sum = 9'(ra) + 9'(rb) + 9'(rc);
      do_add8(ra, rb, rc, s, co, lat, st, ov);
      tests++;
      if ({co, s} !== ref_sum || lat !== 8) begin
        fails++;
        $display("FAIL rand%0d %h+%h+%b got %b_%h lat=%0d want %h",
                 i, ra, rb, rc, co, s, lat, ref_sum);
      end
      tests++;
      if (ov !== 1'b0 || st !== 1'b1) begin
        fails++;
        $display("FAIL rand%0d overlap=%b hold=%b want 0 1",
                 i, ov, st);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_width1();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial ripple adder. Each cycle it feeds one bit position of two WIDTH-bit operands through a single full-adder cell, LSB first.
- The carry is held in a flip-flop between cycles.
- This is the sequencing stage wrapped around the team's one-bit full-adder cell. It consumes that cell's s/cout every cycle and presents a registered multi-bit sum with a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
- clk  in  1  system clock, rising-edge active
- rst  in  1  synchronous, active-high reset
- start  in  1  request a new addition; sampled only in IDLE
- a  in  WIDTH  operand A; captured on the accepted start edge
- b  in  WIDTH  operand B; captured on the accepted start edge
- cin  in  1  carry-in; captured on the accepted start edge
- busy  out  1  high while state is RUN
- done  out  1  one-cycle pulse; sum/cout valid from this cycle on
- sum  out  WIDTH  registered result; holds until the next completion
- cout  out  1  registered final carry-out; holds with sum

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - state becomes IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Operand shift registers, carry FF and bit counter are cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge → load a→shA, b→shB, cin→carry, cnt←0; go to RUN.
  - Otherwise stay in IDLE.
- RUN, at each edge:
  - Cell inputs: shA[0], shB[0], carry.
  - carry←cell cout.
  - Cell s is shifted into an internal accumulator at the MSB; the accumulator shifts right.
  - shA and shB shift right by one.
  - cnt←cnt+1.
  - When cnt==WIDTH-1 at the edge (the WIDTH-th RUN edge):
    - copy the completed accumulator into sum and the final cell cout into cout;
    - go to DONE.
- DONE: lasts exactly one cycle, then IDLE unconditionally.
- busy = (state==RUN). done = (state==DONE). Both are decoded from registered state, with no combinational path from inputs.
- Latency: start accepted at edge E. Result registered at edge E+WIDTH. done is high for the single cycle between edges E+WIDTH and E+WIDTH+1. Throughput is one addition per WIDTH+2 cycles minimum.
- start during RUN or DONE is ignored, not queued. Operand changes after the accepted edge have no effect.
- sum and cout do not change during RUN; they keep the previous result until the completing edge.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). There is no overflow flag.
- Counter width: $clog2(WIDTH) bits, at least 1. For WIDTH=1, RUN lasts exactly one edge.
- Reset mid-operation (rst during RUN or DONE): abort immediately to IDLE with the reset values. No done pulse for the aborted operation. The old sum/cout are cleared to 0.
- rst and start both high at the same edge: rst wins; state stays IDLE.

Decomposition:
- Shared package serial_adder_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;
  - constant SA_DEFAULT_WIDTH = 8.
- One sub-module: fa_cell.
  - Purely combinational one-bit full adder.
  - Ports a, b, cin, s, cout.
  - s = a^b^cin; cout = majority(a,b,cin).
  - Instantiated once.
- Everything else (FSM, shift registers, counter, result registers) stays in serial_adder.

Test Plan:
- After reset with WIDTH=8, hold rst=1 for 2 cycles → busy=0, done=0, sum=0x00, cout=0. Then a=0x00, b=0x00, cin=0, start pulse → done exactly 8 cycles after the start edge, sum=0x00, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. a=0xA5, b=0x5A, cin=1 → sum=0x00, cout=1. a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0. Each is checked on its done pulse, and sum is checked unchanged during busy.
- WIDTH=1 instance, all 8 combinations of (a,b,cin) in the order 000,100,010,110,001,101,011,111 → (cout,sum) = 00,01,01,10,01,10,10,11. done arrives 1 cycle after each start.
- Start a=0x10, b=0x20, cin=0, then at cycle 3 of RUN pulse start with a=0xFF, b=0xFF → second start ignored, result sum=0x30, cout=0, single done pulse.
- Start a=0xFF, b=0xFF, cin=1, then assert rst at cycle 4 of RUN → next cycle busy=0, done never pulses, sum=0x00, cout=0. A fresh start with a=0x03, b=0x04, cin=0 afterwards yields sum=0x07, cout=0.
- Random regression: 1000 random a/b/cin with back-to-back starts issued on the cycle after done → every result matches a+b+cin, and busy/done never overlap.
